// File: rtl/decode_issue_stage.sv
// decode_issue_stage: single-entry decode/issue stage with a 16-entry write scoreboard
// that holds an instruction on RAW/WAW hazards until its register file write has landed.
module decode_issue_stage #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   IF_VALID,
    input  logic [15:0]            IF_INSTR,
    output logic                   IF_READY,
    output logic [3:0]             A1,
    output logic [3:0]             A2,
    output logic                   EX_VALID,
    input  logic                   EX_READY,
    output logic [3:0]             EX_OP,
    output logic [3:0]             EX_RD,
    output logic                   EX_WE,
    output logic [15:0]            EX_IMM,
    input  logic                   WB_WE,
    input  logic [3:0]             WB_A3,
    input  logic                   FLUSH,
    output logic [15:0]            BUSY,
    output logic [STALL_CNT_W-1:0] STALL_CNT
);
    logic [15:0]            ir;
    logic                   ir_valid;
    logic [15:0]            busy;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic [3:0]             op, rd, rs1, rs2;
    logic                   reads_a1, reads_a2, writes, hazard, issue, load;
    logic                   rd_is_src, sext_imm;
    logic [15:0]            set_mask, clr_mask;

    always_comb begin
        op        = ir[15:12];
        rd        = ir[11:8];
        rs1       = ir[7:4];
        rs2       = ir[3:0];
        rd_is_src = (op == 4'hD) || (op == 4'hE);
        sext_imm  = (op == 4'hA) || (op == 4'hC) || (op == 4'hE);
        reads_a1  = (op != 4'hB) && (op != 4'hF);
        reads_a2  = (op <= 4'h9) || rd_is_src;
        writes    = op <= 4'hC;
        A1        = rs1;
        A2        = rd_is_src ? rd : rs2;
        EX_IMM    = sext_imm ? {{12{ir[3]}}, ir[3:0]} : (op == 4'hB) ? {8'h00, ir[7:0]} : 16'h0000;
        // hazards look only at the registered scoreboard; a same-cycle writeback has not landed yet
        hazard    = (reads_a1 && busy[rs1]) || (reads_a2 && busy[A2]) || (writes && busy[rd]);
        EX_VALID  = ir_valid && !hazard && !FLUSH;
        issue     = EX_VALID && EX_READY;
        IF_READY  = !FLUSH && (!ir_valid || issue);
        load      = IF_VALID && IF_READY;
        set_mask  = (issue && writes) ? 16'(1) << rd : 16'h0000;
        clr_mask  = WB_WE ? 16'(1) << WB_A3 : 16'h0000;
    end

    assign EX_OP     = op;
    assign EX_RD     = rd;
    assign EX_WE     = writes;
    assign BUSY      = busy;
    assign STALL_CNT = stall_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ir        <= 16'h0000;
            ir_valid  <= 1'b0;
            busy      <= 16'h0000;
            stall_cnt <= '0;
        end else begin
            if (load) begin
                ir       <= IF_INSTR;
                ir_valid <= 1'b1;
            end else if (issue || FLUSH) begin
                ir_valid <= 1'b0;
            end
            // a new pending write outranks a writeback to the same register
            busy <= (busy & ~clr_mask) | set_mask;
            if (ir_valid && hazard && !FLUSH && !(&stall_cnt))
                stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end
endmodule
